// File: rtl/sram_mmio_responder_pkg.sv
// Shared constants, read-path tag and byte-merge helper for the SRAM/MMIO responder.
package mmio_pkg;

   localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

   localparam logic [15:0] LED_OFF     = 16'hF000;
   localparam logic [15:0] SW_OFF      = 16'hF004;
   localparam logic [15:0] TIMER_OFF   = 16'hF008;
   localparam logic [15:0] SCRATCH_OFF = 16'hF00C;

   // Source of the read data that rdata loads on the edge after a request.
   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_RAM,
      TAG_MMIO
   } rd_tag_e;

   // Replace the bytes of old_v selected by wen with the same bytes of new_v.
   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  wen);
      logic [31:0] res;
      res = old_v;
      for (int unsigned i = 0; i < 4; i++) begin
         if (wen[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_mmio_responder_if.sv
// Data-side SRAM-like request/response bundle between the core and the responder.
interface sram_mmio_responder_if;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output en, output wen, output addr, output wdata, input rdata);
   modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_mmio_responder_ram.sv
// Single-port RAM with synchronous read and four byte-lane write enables.
module sram_bytewen_ram #(
   parameter int unsigned AW = 14
) (
   input  logic          clk,
   input  logic          re,
   input  logic [3:0]    we,
   input  logic [AW-1:0] a,
   input  logic [31:0]   d,
   output logic [31:0]   q
);

   logic [31:0] mem [2**AW];

   // Byte-lane writes and registered read; contents are never reset.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (we[i]) mem[a][8*i +: 8] <= d[8*i +: 8];
      end
      if (re) q <= mem[a];
   end

endmodule

// File: rtl/sram_mmio_responder.sv
// Data-side responder: byte-writable RAM plus an MMIO window (LED, switches,
// timer, scratch) with a sticky error flag for undecoded offsets.
module sram_mmio_responder
   import mmio_pkg::*;
#(
   parameter int unsigned RAM_AW  = 14,
   parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,   // active-high despite the name
   sram_mmio_responder_if.slave  bus,
   input  logic [7:0]            switch_in,
   output logic [15:0]           led,
   output logic                  bus_err
);

   logic        is_mmio;
   logic        rd_req;
   logic        wr_req;
   logic [15:0] off;
   logic        sel_led;
   logic        sel_sw;
   logic        sel_timer;
   logic        sel_scratch;
   logic        sel_bad;
   logic        ram_re;
   logic [3:0]  ram_we;
   logic [31:0] mmio_rd;
   logic [31:0] mmio_q;
   logic [31:0] ram_q;
   logic [31:0] rdata_q;
   logic [31:0] timer;
   logic [31:0] scratch;
   logic [7:0]  sw_meta;
   logic [7:0]  sw_sync;
   rd_tag_e     tag;

   // Region/offset decode and MMIO read mux using pre-edge register values.
   always_comb begin
      is_mmio     = (bus.addr[31:16] == MMIO_HI);
      off         = bus.addr[15:0];
      rd_req      = bus.en && (bus.wen == 4'b0000);
      wr_req      = bus.en && (bus.wen != 4'b0000);
      sel_led     = is_mmio && (off == LED_OFF);
      sel_sw      = is_mmio && (off == SW_OFF);
      sel_timer   = is_mmio && (off == TIMER_OFF);
      sel_scratch = is_mmio && (off == SCRATCH_OFF);
      sel_bad     = is_mmio && !(sel_led || sel_sw || sel_timer || sel_scratch);
      // RAM is gated by reset so no write lands while reset is held.
      ram_re      = rd_req && !is_mmio && !resetn;
      ram_we      = (bus.en && !is_mmio && !resetn) ? bus.wen : 4'b0000;
      mmio_rd     = '0;
      if (sel_led)     mmio_rd = {16'h0000, led};
      if (sel_sw)      mmio_rd = {24'h000000, sw_sync};
      if (sel_timer)   mmio_rd = timer;
      if (sel_scratch) mmio_rd = scratch;
   end

   sram_bytewen_ram #(
      .AW (RAM_AW)
   ) u_ram (
      .clk (clk),
      .re  (ram_re),
      .we  (ram_we),
      .a   (bus.addr[RAM_AW+1:2]),
      .d   (bus.wdata),
      .q   (ram_q)
   );

   // Two-flop synchronizer for the switch inputs.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switch_in;
         sw_sync <= sw_meta;
      end
   end

   // Free-running timer; a write replaces that cycle's increment.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         timer <= '0;
      end else if (wr_req && sel_timer) begin
         timer <= merge(timer, bus.wdata, bus.wen);
      end else begin
         timer <= timer + 32'd1;
      end
   end

   // LED and scratch registers with byte-enabled writes.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         led     <= '0;
         scratch <= '0;
      end else begin
         if (wr_req && sel_led)     led     <= 16'(merge({16'h0000, led}, bus.wdata, bus.wen));
         if (wr_req && sel_scratch) scratch <= merge(scratch, bus.wdata, bus.wen);
      end
   end

   // Sticky error on any access to an undecoded MMIO offset.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         bus_err <= 1'b0;
      end else if (bus.en && sel_bad) begin
         bus_err <= 1'b1;
      end
   end

   // First read stage: tag the source and capture MMIO data alongside the RAM access.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         tag    <= TAG_NONE;
         mmio_q <= '0;
      end else begin
         if (rd_req) tag <= is_mmio ? TAG_MMIO : TAG_RAM;
         else        tag <= TAG_NONE;
         if (rd_req && is_mmio) mmio_q <= mmio_rd;
      end
   end

   // Second read stage: rdata loads the tagged source and otherwise holds.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         rdata_q <= '0;
      end else if (tag == TAG_RAM) begin
         rdata_q <= ram_q;
      end else if (tag == TAG_MMIO) begin
         rdata_q <= mmio_q;
      end
   end

   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_mmio_responder.sv
// Directed self-checking bench for sram_mmio_responder.
module tb_sram_mmio_responder;

   logic        clk;
   logic        resetn;
   logic [7:0]  switch_in;
   logic [15:0] led;
   logic        bus_err;
   int          n_checks;
   int          n_errors;

   sram_mmio_responder_if bus ();

   sram_mmio_responder #(
      .RAM_AW  (14),
      .MMIO_HI (16'hBFAF)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .switch_in (switch_in),
      .led       (led),
      .bus_err   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when observed differs from expected.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one request for one rising edge; inputs change 1 time unit after the edge.
   task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      bus.en    = e;
      bus.wen   = w;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) req(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      resetn    = 1'b1;
      switch_in = 8'h00;
      bus.en    = 1'b0;
      bus.wen   = 4'h0;
      bus.addr  = '0;
      bus.wdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b0;

      // Idle after reset, then timer count since the first post-reset edge.
      idle(5);
      check_eq("rst_rdata", bus.rdata, 32'h0);
      check_eq("rst_led", {16'h0, led}, 32'h0);
      check_eq("rst_bus_err", {31'h0, bus_err}, 32'h0);
      req(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
      idle(1);
      check_eq("timer_after_5", bus.rdata, 32'd5);

      // RAM byte write then read.
      req(1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
      req(1'b1, 4'h4, 32'h0000_0040, 32'h0055_0000);
      req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      idle(1);
      check_eq("ram_bytewen", bus.rdata, 32'hDE55_BEEF);
      req(1'b1, 4'hF, 32'h0000_0044, 32'h1234_5678);
      idle(1);
      check_eq("rdata_hold_on_write", bus.rdata, 32'hDE55_BEEF);
      req(1'b1, 4'h0, 32'h0000_0044, 32'h0);
      req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      check_eq("b2b_rd0", bus.rdata, 32'h1234_5678);
      idle(1);
      check_eq("b2b_rd1", bus.rdata, 32'hDE55_BEEF);

      // Aliasing of high address bits.
      req(1'b1, 4'hF, 32'h0001_0040, 32'h1111_1111);
      req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      idle(1);
      check_eq("ram_alias", bus.rdata, 32'h1111_1111);

      // LED register: low bytes only, visible one edge after the write.
      req(1'b1, 4'hF, 32'hBFAF_F000, 32'hABCD_1234);
      check_eq("led_write", {16'h0, led}, 32'h0000_1234);
      req(1'b1, 4'h2, 32'hBFAF_F000, 32'h0000_5600);
      check_eq("led_byte1", {16'h0, led}, 32'h0000_5634);
      req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      idle(1);
      check_eq("led_read", bus.rdata, 32'h0000_5634);

      // Scratch register byte writes.
      req(1'b1, 4'hF, 32'hBFAF_F00C, 32'hCAFE_F00D);
      req(1'b1, 4'h8, 32'hBFAF_F00C, 32'h1100_0000);
      req(1'b1, 4'h0, 32'hBFAF_F00C, 32'h0);
      idle(1);
      check_eq("scratch_read", bus.rdata, 32'h11FE_F00D);

      // Timer write wins over increment; back-to-back reads track the count.
      req(1'b1, 4'hF, 32'hBFAF_F008, 32'h0000_0100);
      req(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
      req(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
      check_eq("timer_wr_rd0", bus.rdata, 32'h0000_0100);
      req(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
      check_eq("timer_wr_rd1", bus.rdata, 32'h0000_0101);
      req(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
      check_eq("timer_wr_rd2", bus.rdata, 32'h0000_0102);
      idle(1);
      check_eq("timer_wr_rd3", bus.rdata, 32'h0000_0103);
      req(1'b1, 4'h1, 32'hBFAF_F008, 32'h0000_00F0);
      req(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
      idle(1);
      check_eq("timer_byte_wr", bus.rdata, 32'h0000_01F0);

      // Switch synchronizer and read-only switch register.
      switch_in = 8'hA5;
      idle(2);
      req(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
      idle(1);
      check_eq("switch_read", bus.rdata, 32'h0000_00A5);
      req(1'b1, 4'hF, 32'hBFAF_F004, 32'hFFFF_FFFF);
      req(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
      idle(1);
      check_eq("switch_ro", bus.rdata, 32'h0000_00A5);
      check_eq("no_err_yet", {31'h0, bus_err}, 32'h0);

      // Undecoded offset: zero data, sticky error.
      req(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
      check_eq("err_set", {31'h0, bus_err}, 32'h1);
      idle(1);
      check_eq("err_rdata", bus.rdata, 32'h0);
      idle(4);
      check_eq("err_sticky", {31'h0, bus_err}, 32'h1);

      // Reset asserted with a read in flight; RAM write blocked during reset.
      req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      resetn = 1'b1;
      #1;
      check_eq("arst_bus_err", {31'h0, bus_err}, 32'h0);
      check_eq("arst_led", {16'h0, led}, 32'h0);
      check_eq("arst_rdata", bus.rdata, 32'h0);
      req(1'b1, 4'hF, 32'h0000_0040, 32'h0000_0000);
      req(1'b1, 4'hF, 32'h0000_0040, 32'h0000_0000);
      check_eq("rst_hold_rdata", bus.rdata, 32'h0);
      resetn = 1'b0;
      idle(2);
      check_eq("inflight_dropped", bus.rdata, 32'h0);
      req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      idle(1);
      check_eq("ram_no_wr_in_rst", bus.rdata, 32'h1111_1111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
